pipe_mmio_ports: RTL and testbench

- Parametrised memory-mapped I/O peripheral for the 5-stage pipelined computer's MEM stage.
- Generalises the fixed two-input/three-output port scheme to NUM_IN input ports and NUM_OUT output ports.
- Adds per-input synchronisers, sticky change-detect status with write-1-to-clear, an interrupt mask and output write strobes.
- Selected by the MEM-stage address decoder; the CPU accesses it with ordinary lw/sw.

---
 rtl/pipe_mmio_ports.sv | 100 ++++++++++
 tb/tb_pipe_mmio_ports.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/pipe_mmio_ports.sv
// MMIO port block for the MEM stage: synchronised inputs with sticky change status,
// registered outputs with write strobes, masked level interrupt; loads are combinational.
module pipe_mmio_ports #(
  parameter int NUM_IN      = 2,
  parameter int NUM_OUT     = 3,
  parameter int IN_W        = 5,
  parameter int OUT_W       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                     clock,
  input  logic                     resetn,
  input  logic                     io_sel,
  input  logic                     we,
  input  logic [7:0]               addr,
  input  logic [31:0]              wdata,
  output logic [31:0]              rdata,
  input  logic [NUM_IN*IN_W-1:0]   in_ports,
  output logic [NUM_OUT*OUT_W-1:0] out_ports,
  output logic [NUM_OUT-1:0]       out_strobe,
  output logic                     irq
);

  localparam logic [5:0] CHG_WORD = 6'd16;
  localparam logic [5:0] IEN_WORD = 6'd17;

  logic [IN_W-1:0]  sync_q  [NUM_IN][SYNC_STAGES];
  logic [IN_W-1:0]  prev_q  [NUM_IN];
  logic [IN_W-1:0]  in_data [NUM_IN];
  logic [OUT_W-1:0] out_q   [NUM_OUT];
  logic [NUM_IN-1:0] chg_status, irq_en, chg, clr;
  logic [NUM_OUT-1:0] out_hit;
  logic [5:0] word;
  logic wr;
  logic unused;

  assign word   = addr[7:2];
  assign wr     = io_sel & we;
  assign unused = ^{addr[1:0], wdata};

  always_comb begin
    chg = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      in_data[i] = sync_q[i][SYNC_STAGES-1];
      chg[i]     = (in_data[i] != prev_q[i]);
    end
  end

  always_comb begin
    out_hit = '0;
    for (int j = 0; j < NUM_OUT; j++)
      out_hit[j] = wr && (word == 6'(8 + j));
    clr = (wr && word == CHG_WORD) ? wdata[NUM_IN-1:0] : '0;
  end

  // Loads see pre-write state; the new value of a same-cycle store appears next cycle.
  always_comb begin
    rdata = '0;
    for (int i = 0; i < NUM_IN; i++)
      if (word == 6'(i)) rdata[IN_W-1:0] = in_data[i];
    for (int j = 0; j < NUM_OUT; j++)
      if (word == 6'(8 + j)) rdata[OUT_W-1:0] = out_q[j];
    if (word == CHG_WORD) rdata[NUM_IN-1:0] = chg_status;
    if (word == IEN_WORD) rdata[NUM_IN-1:0] = irq_en;
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      for (int i = 0; i < NUM_IN; i++) begin
        for (int s = 0; s < SYNC_STAGES; s++) sync_q[i][s] <= '0;
        prev_q[i] <= '0;
      end
      for (int j = 0; j < NUM_OUT; j++) out_q[j] <= '0;
      chg_status <= '0;
      irq_en     <= '0;
      out_strobe <= '0;
    end else begin
      for (int i = 0; i < NUM_IN; i++) begin
        sync_q[i][0] <= in_ports[i*IN_W +: IN_W];
        for (int s = 1; s < SYNC_STAGES; s++) sync_q[i][s] <= sync_q[i][s-1];
        prev_q[i] <= in_data[i];
      end
      for (int j = 0; j < NUM_OUT; j++)
        if (out_hit[j]) out_q[j] <= wdata[OUT_W-1:0];
      // A fresh change beats a same-cycle W1C so no event is lost.
      chg_status <= chg | (chg_status & ~clr);
      if (wr && word == IEN_WORD) irq_en <= wdata[NUM_IN-1:0];
      out_strobe <= out_hit;
    end
  end

  genvar g;
  generate
    for (g = 0; g < NUM_OUT; g++) begin : g_out
      assign out_ports[g*OUT_W +: OUT_W] = out_q[g];
    end
  endgenerate

  assign irq = |(chg_status & irq_en);

endmodule

// File: tb/tb_pipe_mmio_ports.sv
// Directed bench for pipe_mmio_ports at default parameters.
module tb_pipe_mmio_ports;

  logic        clock = 1'b0;
  logic        resetn, io_sel, we;
  logic [7:0]  addr;
  logic [31:0] wdata, rdata;
  logic [9:0]  in_ports;
  logic [23:0] out_ports;
  logic [2:0]  out_strobe;
  logic        irq;
  int total = 0;
  int bad   = 0;

  pipe_mmio_ports dut (
    .clock(clock), .resetn(resetn), .io_sel(io_sel), .we(we), .addr(addr),
    .wdata(wdata), .rdata(rdata), .in_ports(in_ports), .out_ports(out_ports),
    .out_strobe(out_strobe), .irq(irq)
  );

  always #10 clock = ~clock;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    io_sel = 1'b1; we = 1'b1; addr = a; wdata = d;
    step();
    io_sel = 1'b0; we = 1'b0; wdata = '0;
  endtask

  task automatic rd(input string tag, input logic [7:0] a, input logic [31:0] exp);
    addr = a;
    #1;
    check_val(tag, rdata, exp);
  endtask

  initial begin
    resetn = 1'b0; io_sel = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    in_ports = 10'h007;
    step(); step();
    check_val("rst_out", 32'(out_ports), 32'h0);
    check_val("rst_stb", 32'(out_strobe), 32'h0);
    check_val("rst_irq", 32'(irq), 32'h0);
    rd("rst_w16", 8'h40, 32'h0);
    rd("rst_w17", 8'h44, 32'h0);
    rd("rst_w0", 8'h00, 32'h0);

    // Port 0 held at 7 through reset shows up as a change once released.
    resetn = 1'b1;
    step(); step(); step();
    rd("rel_w0", 8'h00, 32'h7);
    rd("rel_w16", 8'h40, 32'h1);
    check_val("rel_irq", 32'(irq), 32'h0);
    wr(8'h40, 32'h1);
    rd("clr_w16", 8'h40, 32'h0);

    wr(8'h24, 32'h1234_56A5);
    check_val("w9_out", 32'(out_ports), 32'h00A500);
    check_val("w9_stb", 32'(out_strobe), 32'h2);
    rd("w9_rd", 8'h24, 32'h0000_00A5);
    step();
    check_val("w9_stb_off", 32'(out_strobe), 32'h0);

    wr(8'h20, 32'h11);
    check_val("b2b_stb1", 32'(out_strobe), 32'h1);
    wr(8'h20, 32'h11);
    check_val("b2b_stb2", 32'(out_strobe), 32'h1);
    step();
    check_val("b2b_stb_off", 32'(out_strobe), 32'h0);
    check_val("b2b_out", 32'(out_ports), 32'h00A511);

    // Port 1 -> 0x13 before edge k.
    in_ports = 10'h267;
    step();
    rd("sync_k", 8'h04, 32'h0);
    step();
    rd("sync_k1", 8'h04, 32'h13);
    rd("sync_st_k1", 8'h40, 32'h0);
    step();
    rd("sync_st_k2", 8'h40, 32'h2);
    check_val("irq_pre_en", 32'(irq), 32'h0);
    wr(8'h44, 32'h2);
    check_val("irq_en_hi", 32'(irq), 32'h1);
    rd("ien_rd", 8'h44, 32'h2);

    in_ports = 10'h261;
    step(); step(); step();
    rd("st_both", 8'h40, 32'h3);
    wr(8'h44, 32'h1);
    check_val("irq_en0", 32'(irq), 32'h1);
    // Second change on port 0 is detected in the same cycle as the W1C.
    in_ports = 10'h262;
    step(); step();
    wr(8'h40, 32'h1);
    rd("w1c_coll", 8'h40, 32'h3);
    check_val("w1c_coll_irq", 32'(irq), 32'h1);
    wr(8'h40, 32'h1);
    rd("w1c_clr", 8'h40, 32'h2);
    check_val("w1c_irq_drop", 32'(irq), 32'h0);

    wr(8'h00, 32'hFFFF_FFFF);
    check_val("ro_stb", 32'(out_strobe), 32'h0);
    rd("ro_w0", 8'h00, 32'h2);
    wr(8'h50, 32'hFFFF_FFFF);
    check_val("um_stb", 32'(out_strobe), 32'h0);
    rd("um_w20", 8'h50, 32'h0);
    check_val("um_out", 32'(out_ports), 32'h00A511);
    rd("um_w17", 8'h44, 32'h1);

    in_ports = 10'h263;
    step(); step(); step();
    rd("pre_rst_st", 8'h40, 32'h3);
    wr(8'h28, 32'h5A);
    check_val("pre_rst_stb", 32'(out_strobe), 32'h4);
    check_val("pre_rst_irq", 32'(irq), 32'h1);
    resetn = 1'b0;
    step();
    check_val("mrst_stb", 32'(out_strobe), 32'h0);
    rd("mrst_st", 8'h40, 32'h0);
    check_val("mrst_irq", 32'(irq), 32'h0);
    check_val("mrst_out", 32'(out_ports), 32'h0);
    resetn = 1'b1;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
